prog_rom_arbiter: RTL
=====================

// Module: prog_rom_arbiter
// PURPOSE
//   Shares the single read port of the synchronous program ROM (10-bit address, 18-bit word,
//   1-cycle read latency) between the CPU instruction fetch and a debug/dump reader.
//   CPU fetch has fixed priority; a starvation counter forces a debug slot after a bounded wait.
//   Tags each in-flight read and routes the returned word to its owner with a 1-cycle valid pulse.
// PARAMETERS
//   ADDR_W        10   ROM address width
//   DATA_W        18   ROM word width
//   DBG_MAX_WAIT  8    consecutive blocked debug cycles before debug is forced; 0 = never forced
// PORTS
//   PROG_CLK      in   1       clock, all logic on rising edge
//   PROG_RST_N    in   1       synchronous active-low reset
//   CPU_REQ       in   1       CPU fetch request
//   CPU_ADDR      in   ADDR_W  CPU fetch address (PC)
//   CPU_GNT       out  1       CPU request accepted this cycle (combinational)
//   CPU_IR_VALID  out  1       CPU_IR holds the word for the address granted last cycle
//   CPU_IR        out  DATA_W  instruction word to CPU
//   DBG_REQ       in   1       debug read request
//   DBG_ADDR      in   ADDR_W  debug read address
//   DBG_GNT       out  1       debug request accepted this cycle (combinational)
//   DBG_VALID     out  1       DBG_DATA holds the word for the address granted last cycle
//   DBG_DATA      out  DATA_W  word to debug reader
//   ROM_ADDR      out  ADDR_W  address to ROM (combinational mux)
//   ROM_DATA      in   DATA_W  registered ROM output, valid 1 cycle after ROM_ADDR sampled
// BEHAVIOUR
//   - Grant (combinational, at most one of CPU_GNT/DBG_GNT high; both 0 while PROG_RST_N=0):
//     boost=1 -> DBG_GNT=DBG_REQ, CPU_GNT=CPU_REQ&~DBG_REQ; boost=0 -> CPU_GNT=CPU_REQ,
//     DBG_GNT=DBG_REQ&~CPU_REQ. Requester holds REQ/ADDR until its GNT; ADDR sampled on GNT edge.
//   - ROM_ADDR = DBG_ADDR when DBG_GNT, else CPU_ADDR (CPU_ADDR also when idle).
//   - Owner FSM (registered tag of read in flight): IDLE, CPU_RD, DBG_RD.
//     Each edge: CPU_GNT -> CPU_RD; DBG_GNT -> DBG_RD; no grant -> IDLE. Back-to-back grants allowed
//     every cycle (full throughput, one read per cycle).
//   - Return: CPU_IR_VALID = (state==CPU_RD), DBG_VALID = (state==DBG_RD); latency grant->valid = 1 cycle.
//     CPU_IR/DBG_DATA = ROM_DATA while own valid high; otherwise hold last delivered word
//     (per-owner hold register loaded on edge ending a valid cycle).
//   - Starvation counter wait_cnt, width clog2(DBG_MAX_WAIT+1): increments (saturating at
//     DBG_MAX_WAIT) when DBG_REQ & ~DBG_GNT; clears on DBG_GNT or DBG_REQ=0.
//     boost = (DBG_MAX_WAIT!=0) & (wait_cnt==DBG_MAX_WAIT). Boost lasts exactly the one granted cycle.
//   - Simultaneous CPU_REQ+DBG_REQ with boost=0: CPU wins, debug waits, counter increments.
//   - Address wrap: no arithmetic on addresses; 10'h3FF is a normal address.
//   - Reset (sync, PROG_RST_N=0 at edge): state=IDLE, wait_cnt=0, hold regs=0. Outputs in reset and
//     the first cycle after: CPU_GNT=DBG_GNT=0 during reset, CPU_IR_VALID=DBG_VALID=0, CPU_IR=DBG_DATA=0.
//     Reset mid-read discards the in-flight word: no valid pulse follows.
// TESTING
//   1 Reset: PROG_RST_N=0 2 cycles with CPU_REQ=1 -> no GNT, no valid, CPU_IR=0; release -> first GNT same cycle.
//   2 CPU stream: CPU_ADDR 0,1,2 on 3 cycles with ROM[n]=n+18'h100 -> CPU_IR_VALID 3 cycles, CPU_IR 100,101,102, 1 cycle late.
//   3 Contention, DBG_MAX_WAIT=8: CPU_REQ=1 always, DBG_REQ=1 addr 10'h3FF -> DBG_GNT on 9th cycle,
//     CPU_GNT=0 that cycle, DBG_DATA=ROM[3FF] next cycle, CPU_IR held unchanged, wait_cnt=0.
//   4 DBG_MAX_WAIT=0: same stimulus for 50 cycles -> DBG_GNT never asserted.
//   5 Interleave: CPU, DBG, CPU grants on consecutive cycles -> valids alternate CPU,DBG,CPU; each owner
//     gets only its own word; non-owner output holds.
//   6 Reset mid-read: CPU_GNT at cycle k, PROG_RST_N=0 at edge k+1 -> CPU_IR_VALID stays 0, CPU_IR=0.

Source files
------------

// File: rtl/prog_rom_arbiter_if.sv
// Bus bundle between the program ROM arbiter, its two requesters (CPU fetch, debug reader)
// and the synchronous ROM read port.
interface prog_rom_arbiter_if #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 18
);
  logic              CPU_REQ;
  logic [ADDR_W-1:0] CPU_ADDR;
  logic              CPU_GNT;
  logic              CPU_IR_VALID;
  logic [DATA_W-1:0] CPU_IR;
  logic              DBG_REQ;
  logic [ADDR_W-1:0] DBG_ADDR;
  logic              DBG_GNT;
  logic              DBG_VALID;
  logic [DATA_W-1:0] DBG_DATA;
  logic [ADDR_W-1:0] ROM_ADDR;
  logic [DATA_W-1:0] ROM_DATA;

  // arbiter side
  modport slave (
    input  CPU_REQ, CPU_ADDR, DBG_REQ, DBG_ADDR, ROM_DATA,
    output CPU_GNT, CPU_IR_VALID, CPU_IR, DBG_GNT, DBG_VALID, DBG_DATA, ROM_ADDR
  );

  // requesters + ROM side
  modport master (
    output CPU_REQ, CPU_ADDR, DBG_REQ, DBG_ADDR, ROM_DATA,
    input  CPU_GNT, CPU_IR_VALID, CPU_IR, DBG_GNT, DBG_VALID, DBG_DATA, ROM_ADDR
  );
endinterface

// File: rtl/prog_rom_arbiter.sv
// Shares the 1-cycle-latency program ROM port between CPU fetch (fixed priority) and a debug
// reader, with a starvation counter that forces one debug slot after DBG_MAX_WAIT blocked cycles.
module prog_rom_arbiter #(
  parameter int ADDR_W       = 10,
  parameter int DATA_W       = 18,
  parameter int DBG_MAX_WAIT = 8
) (
  input  logic              PROG_CLK,
  input  logic              PROG_RST_N,
  prog_rom_arbiter_if.slave bus
);
  // width kept >= 1 so DBG_MAX_WAIT=0 still elaborates a legal counter
  localparam int CW = (DBG_MAX_WAIT > 0) ? $clog2(DBG_MAX_WAIT + 1) : 1;
  localparam logic [CW-1:0] MAX_C = CW'(DBG_MAX_WAIT);

  typedef enum logic [1:0] {IDLE, CPU_RD, DBG_RD} own_e;

  own_e              state_q, state_d;
  logic [CW-1:0]     wait_cnt_q, wait_cnt_d;
  logic [DATA_W-1:0] cpu_hold_q, cpu_hold_d;
  logic [DATA_W-1:0] dbg_hold_q, dbg_hold_d;
  logic              boost, cpu_gnt, dbg_gnt, cpu_vld, dbg_vld;

  always_comb begin
    boost   = (DBG_MAX_WAIT != 0) && (wait_cnt_q == MAX_C);
    cpu_gnt = 1'b0;
    dbg_gnt = 1'b0;
    if (PROG_RST_N) begin
      if (boost) begin
        dbg_gnt = bus.DBG_REQ;
        cpu_gnt = bus.CPU_REQ & ~bus.DBG_REQ;
      end else begin
        cpu_gnt = bus.CPU_REQ;
        dbg_gnt = bus.DBG_REQ & ~bus.CPU_REQ;
      end
    end
  end

  assign bus.CPU_GNT  = cpu_gnt;
  assign bus.DBG_GNT  = dbg_gnt;
  assign bus.ROM_ADDR = dbg_gnt ? bus.DBG_ADDR : bus.CPU_ADDR;

  // owner FSM: tag of the read whose word arrives on ROM_DATA next cycle
  always_ff @(posedge PROG_CLK) begin
    if (!PROG_RST_N) state_q <= IDLE;
    else             state_q <= state_d;
  end

  always_comb begin
    state_d = IDLE;
    if (cpu_gnt)      state_d = CPU_RD;
    else if (dbg_gnt) state_d = DBG_RD;
  end

  always_comb begin
    cpu_vld = PROG_RST_N && (state_q == CPU_RD);
    dbg_vld = PROG_RST_N && (state_q == DBG_RD);
  end

  always_comb begin
    wait_cnt_d = '0;
    if (bus.DBG_REQ && !dbg_gnt)
      wait_cnt_d = (wait_cnt_q == MAX_C) ? wait_cnt_q : wait_cnt_q + 1'b1;
    cpu_hold_d = cpu_vld ? bus.ROM_DATA : cpu_hold_q;
    dbg_hold_d = dbg_vld ? bus.ROM_DATA : dbg_hold_q;
  end

  always_ff @(posedge PROG_CLK) begin
    if (!PROG_RST_N) begin
      wait_cnt_q <= '0;
      cpu_hold_q <= '0;
      dbg_hold_q <= '0;
    end else begin
      wait_cnt_q <= wait_cnt_d;
      cpu_hold_q <= cpu_hold_d;
      dbg_hold_q <= dbg_hold_d;
    end
  end

  assign bus.CPU_IR_VALID = cpu_vld;
  assign bus.DBG_VALID    = dbg_vld;
  assign bus.CPU_IR       = !PROG_RST_N ? '0 : (cpu_vld ? bus.ROM_DATA : cpu_hold_q);
  assign bus.DBG_DATA     = !PROG_RST_N ? '0 : (dbg_vld ? bus.ROM_DATA : dbg_hold_q);
endmodule
